// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin, packet-granular arbiter sharing one UART_TX byte
//            transmitter among NUM_REQ requesters, with a lock timeout that
//            revokes the grant from an owner that stalls mid-packet.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   o_TX_DV,
  output logic [7:0]             o_TX_Byte,
  input  logic                   i_TX_Active,
  input  logic                   i_TX_Done
);

  localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_HOLD      = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_IDX_W-1:0]   r_ptr;
  logic                 r_last;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0]   r_req_ready;
  logic [NUM_REQ-1:0]   r_grant;
  logic                 r_timeout_err;
  logic                 r_tx_dv;
  logic [7:0]           r_tx_byte;

  state_t               w_state_nxt;
  logic [c_IDX_W-1:0]   w_idx_nxt;
  logic [c_IDX_W-1:0]   w_ptr_nxt;
  logic                 w_last_nxt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [NUM_REQ-1:0]   w_req_ready_nxt;
  logic [NUM_REQ-1:0]   w_grant_nxt;
  logic                 w_timeout_nxt;
  logic [7:0]           w_tx_byte_nxt;
  logic                 w_launch;
  logic [c_IDX_W-1:0]   w_launch_idx;
  logic                 w_sel_found;
  logic [c_IDX_W-1:0]   w_sel_idx;
  logic [c_IDX_W-1:0]   w_cand;

  // Next-state, arbitration and launch decode; every output is registered.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_ptr_nxt       = r_ptr;
    w_last_nxt      = r_last;
    w_cnt_nxt       = r_cnt;
    w_req_ready_nxt = '0;
    w_grant_nxt     = r_grant;
    w_timeout_nxt   = 1'b0;
    w_tx_byte_nxt   = r_tx_byte;
    w_launch        = 1'b0;
    w_launch_idx    = r_idx;
    w_sel_found     = 1'b0;
    w_sel_idx       = '0;
    w_cand          = '0;

    // Scan from the farthest candidate back to ptr+1 so the nearest wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = c_IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      if (req_valid[w_cand]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (w_sel_found && !i_TX_Active) begin
          w_launch     = 1'b1;
          w_launch_idx = w_sel_idx;
          w_state_nxt  = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (i_TX_Done) begin
          if (r_last) begin
            w_grant_nxt = '0;
            w_ptr_nxt   = r_idx;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // A valid byte on the limit cycle still launches; timeout loses.
        if (req_valid[r_idx] && !i_TX_Active) begin
          w_launch     = 1'b1;
          w_launch_idx = r_idx;
          w_state_nxt  = S_WAIT_DONE;
        end else if (r_cnt == c_CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_timeout_nxt = 1'b1;
          w_grant_nxt   = '0;
          w_ptr_nxt     = r_idx;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_launch) begin
      w_idx_nxt                     = w_launch_idx;
      w_last_nxt                    = req_last[w_launch_idx];
      w_tx_byte_nxt                 = req_data[{w_launch_idx, 3'b000} +: 8];
      w_grant_nxt                   = '0;
      w_grant_nxt[w_launch_idx]     = 1'b1;
      w_req_ready_nxt[w_launch_idx] = 1'b1;
    end
  end

  // State and output registers; ptr resets to the last index so requester 0 leads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_ptr         <= c_IDX_W'(NUM_REQ - 1);
      r_last        <= 1'b0;
      r_cnt         <= '0;
      r_req_ready   <= '0;
      r_grant       <= '0;
      r_timeout_err <= 1'b0;
      r_tx_dv       <= 1'b0;
      r_tx_byte     <= 8'h00;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_ptr         <= w_ptr_nxt;
      r_last        <= w_last_nxt;
      r_cnt         <= w_cnt_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_grant       <= w_grant_nxt;
      r_timeout_err <= w_timeout_nxt;
      r_tx_dv       <= w_launch;
      r_tx_byte     <= w_tx_byte_nxt;
    end
  end

  assign req_ready   = r_req_ready;
  assign grant       = r_grant;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout_err;
  assign o_TX_DV     = r_tx_dv;
  assign o_TX_Byte   = r_tx_byte;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART_TX byte transmitter among `NUM_REQ` requesters (camera status, IPM debug dump, RX loopback echo, etc.). It grants the transmitter per packet rather than per byte, so multi-byte frames are never interleaved. A lock timeout releases the grant if the owner stalls mid-packet. It sits between the requester logic and UART_TX, driving UART_TX's data-valid/byte inputs and consuming its active/done outputs.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `LOCK_TIMEOUT`, 1024: number of idle clk cycles in HOLD before a stalled packet owner loses the grant; minimum 2.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: requester i has a byte ready.
- `req_data` in 8*NUM_REQ: byte of requester i at bits [8i+7:8i].
- `req_last` in NUM_REQ: the byte offered by requester i ends its packet.
- `req_ready` out NUM_REQ: one-cycle pulse; byte of requester i accepted.
- `grant` out NUM_REQ: one-hot current owner; 0 when no owner.
- `busy` out 1: high whenever state ≠ IDLE.
- `timeout_err` out 1: one-cycle pulse when a grant is revoked by timeout.
- `o_TX_DV` out 1: one-cycle start pulse to UART_TX.
- `o_TX_Byte` out 8: byte to UART_TX; held stable until the next launch.
- `i_TX_Active` in 1: UART_TX is shifting a byte.
- `i_TX_Done` in 1: UART_TX one-cycle completion pulse.

## Operation
- Registers: 2-bit state, owner index, rotate pointer `ptr`, latched last flag, timeout counter of width clog2(LOCK_TIMEOUT).
- **IDLE**
  - If any `req_valid` and `!i_TX_Active`, select the first valid index in the order ptr+1, ptr+2, … (mod NUM_REQ).
  - Launch the selected byte and go to WAIT_DONE.
- **Launch** (registered, visible the next cycle):
  - `o_TX_DV`=1 and `req_ready[idx]`=1 for exactly one cycle.
  - `o_TX_Byte`=`req_data[idx]`.
  - `grant`=onehot(idx).
  - Latch `req_last[idx]`.
- **WAIT_DONE**
  - Ignore all `req_valid`.
  - On `i_TX_Done`:
    - If the latched last flag is 1: clear `grant`, set ptr=idx, go to IDLE.
    - Otherwise: clear the counter and go to HOLD.
- **HOLD**
  - Only `req_valid[idx]` is considered; other requesters are blocked.
  - If `req_valid[idx]` and `!i_TX_Active`: launch and go to WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches LOCK_TIMEOUT-1 with no launch: pulse `timeout_err`, clear `grant`, set ptr=idx, go to IDLE.
- Boundary rules:
  - Valid and timeout on the same HOLD cycle: valid wins, no error.
  - `i_TX_Done` in IDLE or HOLD is ignored.
  - `req_last` is sampled only with an accepted byte.
  - A requester must not re-present the same byte after seeing `req_ready`. The arbiter never samples `req_valid` during the 2 cycles after a launch (it is in WAIT_DONE).
- Reset, including mid-packet:
  - Next cycle: state=IDLE, ptr=NUM_REQ-1 (so requester 0 has first priority), counter=0.
  - Output reset values: `req_ready`=0, `grant`=0, `busy`=0, `timeout_err`=0, `o_TX_DV`=0, `o_TX_Byte`=8'h00.
  - A byte already inside UART_TX is not aborted. After reset the arbiter waits for `i_TX_Active` low before the next launch.

## Timing
- Request to launch: `req_valid` sampled high in IDLE at cycle N → `o_TX_DV`/`req_ready` high at N+1, `busy` high from N+1.
- Done (last byte) at cycle D → `grant`=0 and `busy`=0 at D+1. The earliest next `o_TX_DV` is at D+2.
- Done (not last) at D → HOLD at D+1. If valid is present at D+1, the next `o_TX_DV` is at D+2.
- Timeout: HOLD entered at D+1 with no valid → `timeout_err` at D+LOCK_TIMEOUT+1, `grant` cleared in the same cycle.
- `o_TX_DV` and `req_ready` are never high for two consecutive cycles.

## Test plan
- **Single byte:** requester 0 offers 0x55 with last=1 at cycle 10 → at cycle 11 `o_TX_DV`=1, `o_TX_Byte`=0x55, `req_ready`=0001, `grant`=0001. One cycle after `i_TX_Done`, `grant`=0 and `busy`=0. Decoded serial output is 0x55.
- **Fairness:** all four requesters valid with last=1 and bytes 0x10..0x13 → bytes sent in order 0x10, 0x11, 0x12, 0x13. If requester 1 re-requests 0x21 while 3 is transmitting, the next byte sent is 0x21 (after 0, since ptr=3).
- **Packet lock:** requester 1 sends 0xA1, 0xA2, 0xA3 (last on 0xA3) while requester 2 holds 0xB0 valid throughout → serial order is A1, A2, A3, B0, and `grant` stays 0010 across the whole frame.
- **Timeout:** with LOCK_TIMEOUT=16, requester 0 sends 0x01 with last=0 then drops valid, requester 3 pending 0x33 → `timeout_err` pulses 16 cycles after HOLD entry, then 0x33 launches 1 cycle after the return to IDLE. Also raise requester 0 valid exactly on the limit cycle → launch occurs and no error is reported.
- **Reset mid-packet:** assert `rst` during WAIT_DONE of byte 2 of a 3-byte frame → all outputs at reset values the next cycle. With requesters 0 and 2 valid after reset, requester 0 is served first.
- **TX busy gating:** in IDLE, hold `i_TX_Active`=1 with requester 2 valid → no `o_TX_DV`. Drop `i_TX_Active` at cycle M → `o_TX_DV` at M+1.
